// File: rtl/amba_arbiter.sv
// amba_arbiter: round-robin AHB arbiter plus master-side address/write-data mux.
// Parks the bus on master 0 when idle and bounds bus tenure while others wait.
// Optional locked transfers: define AMBA_ARB_LOCK_EN.

package amba_pkg;
   localparam int AWIDTH = 32;
   localparam int DWIDTH = 32;
endpackage

module amba_arbiter
   import amba_pkg::*;
#(
   parameter  int NMASTER    = 4,
   parameter  int MAX_TENURE = 16,
   localparam int MWIDTH     = $clog2(NMASTER)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NMASTER-1:0]                hbusreq,
   input  logic [NMASTER-1:0]                hlock,
   input  logic [NMASTER-1:0][AWIDTH-1:0]    haddr_m,
   input  logic [NMASTER-1:0][1:0]           htrans_m,
   input  logic [NMASTER-1:0]                hwrite_m,
   input  logic [NMASTER-1:0][2:0]           hsize_m,
   input  logic [NMASTER-1:0][DWIDTH-1:0]    hwdata_m,
   input  logic                              hready,
   output logic [NMASTER-1:0]                hgrant,
   output logic [MWIDTH-1:0]                 hmaster,
   output logic [MWIDTH-1:0]                 hmaster_d,
   output logic                              hmastlock,
   output logic [AWIDTH-1:0]                 haddr,
   output logic [1:0]                        htrans,
   output logic                              hwrite,
   output logic [2:0]                        hsize,
   output logic [DWIDTH-1:0]                 hwdata
);

   localparam int TW = $clog2(MAX_TENURE);
   localparam logic [TW-1:0] TEN_MAX = TW'(MAX_TENURE - 1);

   typedef enum logic {PARK, OWN} state_t;

   state_t              state_q, state_d;
   logic [MWIDTH-1:0]   own_q, own_d;       // address-phase owner
   logic [MWIDTH-1:0]   dmst_q, dmst_d;     // data-phase owner
   logic [MWIDTH-1:0]   last_q, last_d;     // last real owner, RR base while parked
   logic [TW-1:0]       ten_q, ten_d;
   logic [NMASTER-1:0]  grant_q, grant_d;
   logic                lock_q, lock_d;

   logic [MWIDTH-1:0]   winner;
   logic                active, others, rearb;

   // First requester scanning upward from base+1 with wrap; base itself is checked last.
   function automatic logic [MWIDTH-1:0] rr_pick(input logic [NMASTER-1:0] req,
                                                 input logic [MWIDTH-1:0]  base);
      logic [MWIDTH-1:0] pick;
      int                idx;
      pick = base;
      for (int k = NMASTER; k >= 1; k--) begin
         idx = (int'(base) + k) % NMASTER;
         if (req[idx]) pick = MWIDTH'(idx);
      end
      return pick;
   endfunction

   // Next-state: arbitration decision, tenure count and grant encoding on hready cycles.
   always_comb begin
      state_d = state_q;
      own_d   = own_q;
      dmst_d  = dmst_q;
      last_d  = last_q;
      ten_d   = ten_q;
      lock_d  = lock_q;
      active  = (state_q == OWN) && htrans_m[own_q][1];
      others  = |(hbusreq & ~(NMASTER'(1) << own_q));
      winner  = rr_pick(hbusreq, (state_q == PARK) ? last_q : own_q);
      rearb   = !hbusreq[own_q] || (htrans_m[own_q] == 2'b00) ||
                ((ten_q == TEN_MAX) && active && others);
`ifdef AMBA_ARB_LOCK_EN
      if (hlock[own_q]) rearb = 1'b0;
`endif
      if (hready) begin
         dmst_d = own_q;
         case (state_q)
            PARK: if (|hbusreq) begin
               state_d = OWN;
               own_d   = winner;
            end
            OWN: if (rearb) begin
               if (|hbusreq) begin
                  own_d = winner;
               end else begin
                  state_d = PARK;
                  own_d   = '0;
               end
            end
            default: state_d = PARK;
         endcase
         if ((state_d != state_q) || (own_d != own_q)) ten_d = '0;
         else if (active && (ten_q != TEN_MAX))      ten_d = ten_q + 1'b1;
         if (state_d == OWN) last_d = own_d;
`ifdef AMBA_ARB_LOCK_EN
         lock_d = (state_d == OWN) && hlock[own_d];
`else
         lock_d = 1'b0;
`endif
      end
      grant_d = NMASTER'(1) << own_d;
   end

   // State registers; reset wins over hready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PARK;
         own_q   <= '0;
         dmst_q  <= '0;
         last_q  <= '0;
         ten_q   <= '0;
         grant_q <= NMASTER'(1);
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         dmst_q  <= dmst_d;
         last_q  <= last_d;
         ten_q   <= ten_d;
         grant_q <= grant_d;
         lock_q  <= lock_d;
      end
   end

`ifndef AMBA_ARB_LOCK_EN
   logic hlock_unused;
   assign hlock_unused = ^hlock;
`endif

   assign hgrant    = grant_q;
   assign hmaster   = own_q;
   assign hmaster_d = dmst_q;
   assign hmastlock = lock_q;
   assign haddr     = haddr_m[own_q];
   assign htrans    = (state_q == PARK) ? 2'b00 : htrans_m[own_q];
   assign hwrite    = hwrite_m[own_q];
   assign hsize     = hsize_m[own_q];
   assign hwdata    = hwdata_m[dmst_q];

endmodule

// File: tb/tb_amba_arbiter.sv
// Randomized and directed bench for amba_arbiter against a behavioural arbiter model.
module tb_amba_arbiter;
   import amba_pkg::*;

   localparam int NM = 4;
   localparam int MT = 16;
   localparam int MW = 2;

   logic                        clk = 1'b0;
   logic                        rst;
   logic [NM-1:0]               hbusreq, hlock, hwrite_m;
   logic [NM-1:0][AWIDTH-1:0]   haddr_m;
   logic [NM-1:0][1:0]          htrans_m;
   logic [NM-1:0][2:0]          hsize_m;
   logic [NM-1:0][DWIDTH-1:0]   hwdata_m;
   logic                        hready;
   logic [NM-1:0]               hgrant;
   logic [MW-1:0]               hmaster, hmaster_d;
   logic                        hmastlock;
   logic [AWIDTH-1:0]           haddr;
   logic [1:0]                  htrans;
   logic                        hwrite;
   logic [2:0]                  hsize;
   logic [DWIDTH-1:0]           hwdata;

   int n_chk  = 0;
   int n_fail = 0;
   bit do_chk = 0;

   // reference model state
   bit m_park  = 1;
   int m_own   = 0;
   int m_down  = 0;
   int m_last  = 0;
   int m_beats = 0;
   bit m_lock  = 0;

   amba_arbiter #(.NMASTER(NM), .MAX_TENURE(MT)) dut (
      .clk(clk), .rst(rst), .hbusreq(hbusreq), .hlock(hlock), .haddr_m(haddr_m),
      .htrans_m(htrans_m), .hwrite_m(hwrite_m), .hsize_m(hsize_m), .hwdata_m(hwdata_m),
      .hready(hready), .hgrant(hgrant), .hmaster(hmaster), .hmaster_d(hmaster_d),
      .hmastlock(hmastlock), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
      .hsize(hsize), .hwdata(hwdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int rr_next(input int base, input logic [NM-1:0] req);
      for (int k = 1; k <= NM; k++)
         if (req[(base + k) % NM]) return (base + k) % NM;
      return base;
   endfunction

   task automatic model_step();
      int nown;
      bit npark, any, others, active, rearb;
      if (rst) begin
         m_park = 1; m_own = 0; m_down = 0; m_last = 0; m_beats = 0; m_lock = 0;
         return;
      end
      if (!hready) return;
      any    = (hbusreq != 0);
      others = 0;
      for (int i = 0; i < NM; i++) if (i != m_own && hbusreq[i]) others = 1;
      active = !m_park && (htrans_m[m_own] >= 2);
      npark  = m_park;
      nown   = m_own;
      if (m_park) begin
         if (any) begin npark = 0; nown = rr_next(m_last, hbusreq); end
      end else begin
         rearb = !hbusreq[m_own] || (htrans_m[m_own] == 0) ||
                 (m_beats == MT - 1 && active && others);
`ifdef AMBA_ARB_LOCK_EN
         if (hlock[m_own]) rearb = 0;
`endif
         if (rearb) begin
            if (any) nown = rr_next(m_own, hbusreq);
            else begin npark = 1; nown = 0; end
         end
      end
      m_down = m_own;
      if (npark != m_park || nown != m_own) m_beats = 0;
      else if (active && m_beats < MT - 1) m_beats++;
      if (!npark) m_last = nown;
`ifdef AMBA_ARB_LOCK_EN
      m_lock = !npark && hlock[nown];
`endif
      m_park = npark;
      m_own  = nown;
   endtask

   task automatic check_all();
      chk("hgrant",    hgrant,    64'(1) << m_own);
      chk("hmaster",   hmaster,   m_own);
      chk("hmaster_d", hmaster_d, m_down);
      chk("hmastlock", hmastlock, m_lock);
      chk("haddr",     haddr,     haddr_m[m_own]);
      chk("htrans",    htrans,    m_park ? 2'b00 : htrans_m[m_own]);
      chk("hwrite",    hwrite,    hwrite_m[m_own]);
      chk("hsize",     hsize,     hsize_m[m_own]);
      chk("hwdata",    hwdata,    hwdata_m[m_down]);
   endtask

   // Inputs are set at the falling edge; outputs checked 1ns later, model advanced at rising edge.
   task automatic cyc();
      #1;
      if (do_chk) check_all();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic set_m(input int i, input bit req, input logic [1:0] tr, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
      hbusreq[i] = req; htrans_m[i] = tr; hwrite_m[i] = wr;
      haddr_m[i] = a;   hwdata_m[i] = d;  hsize_m[i]  = 3'd2;
   endtask

   task automatic clear_all();
      for (int i = 0; i < NM; i++) set_m(i, 0, 2'b00, 0, $urandom, $urandom);
      hlock  = '0;
      hready = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   // Masters 1 and 2 burst continuously; checks 16-beat tenures, alternation and hmaster_d lag.
   task automatic run_pair(input int n);
      int prev, run, prev_hm;
      prev = -1; run = 0; prev_hm = 0;
      for (int c = 0; c < n; c++) begin
         set_m(1, 1, 2'($urandom_range(2, 3)), $urandom_range(0, 1), $urandom, $urandom);
         set_m(2, 1, 2'($urandom_range(2, 3)), $urandom_range(0, 1), $urandom, $urandom);
         #1;
         if (c > 0) chk("hmd_lag", hmaster_d, prev_hm);
         if (int'(hmaster) == prev) run++;
         else begin
            if (prev == 1 || prev == 2) begin
               chk("tenure_len", run, MT);
               chk("rr_alt", hmaster, (prev == 1) ? 2 : 1);
            end
            prev = hmaster;
            run  = 1;
         end
         prev_hm = hmaster;
         cyc();
      end
   endtask

   initial begin
      rst = 1'b1;
      clear_all();
      @(negedge clk);
      cyc();
      do_chk = 1;
      do_reset();

      // idle bus stays parked on master 0
      for (int c = 0; c < 20; c++) begin
         #1;
         chk("park_grant", hgrant, 4'b0001);
         chk("park_hm", hmaster, 0);
         chk("park_htrans", htrans, 2'b00);
         cyc();
      end

      // two continuous requesters share the bus in 16-beat tenures
      run_pair(70);

      // master 3 write, data phase stretched by three wait states
      clear_all(); do_reset();
      set_m(3, 1, 2'b10, 1, 32'h0000_1004, 32'hDEADBEEF);
      cyc();
      #1;
      chk("t3_grant", hgrant, 4'b1000);
      chk("t3_haddr", haddr, 32'h0000_1004);
      chk("t3_hwrite", hwrite, 1);
      cyc();
      htrans_m[3] = 2'b00;
      set_m(0, 1, 2'b10, 0, $urandom, $urandom);
      hready = 1'b0;
      repeat (3) begin
         #1;
         chk("t3_hwdata", hwdata, 32'hDEADBEEF);
         chk("t3_hmd", hmaster_d, 3);
         chk("t3_frz_grant", hgrant, 4'b1000);
         cyc();
      end
      hready = 1'b1;
      #1 chk("t3_hwdata_last", hwdata, 32'hDEADBEEF);
      cyc();
      #1 chk("t3_handover", hgrant, 4'b0001);

      // owner drops request while master 0 waits, then bus parks
      clear_all(); do_reset();
      set_m(2, 1, 2'b10, 0, $urandom, $urandom);
      cyc(); cyc();
      #1 chk("t4_own2", hgrant, 4'b0100);
      set_m(2, 0, 2'b11, 0, $urandom, $urandom);
      set_m(0, 1, 2'b10, 0, $urandom, $urandom);
      cyc();
      #1;
      chk("t4_grant0", hgrant, 4'b0001);
      chk("t4_htrans0", htrans, 2'b10);
      set_m(0, 0, 2'b10, 0, $urandom, $urandom);
      cyc();
      #1 chk("t4_park_htrans", htrans, 2'b00);

      // reset mid-burst, then a fresh full tenure for master 1
      clear_all(); do_reset();
      run_pair(6);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      chk("t5_rst_grant", hgrant, 4'b0001);
      chk("t5_rst_hm", hmaster, 0);
      chk("t5_rst_hmd", hmaster_d, 0);
      chk("t5_rst_htrans", htrans, 2'b00);
      run_pair(40);

`ifdef AMBA_ARB_LOCK_EN
      // locked owner keeps the bus past tenure expiry
      clear_all(); do_reset();
      set_m(1, 1, 2'b10, 0, $urandom, $urandom);
      set_m(2, 1, 2'b10, 0, $urandom, $urandom);
      hlock[1] = 1'b1;
      cyc();
      for (int c = 0; c < 40; c++) begin
         htrans_m[1] = 2'($urandom_range(2, 3));
         #1;
         chk("lk_hm", hmaster, 1);
         chk("lk_ml", hmastlock, 1);
         cyc();
      end
      hlock[1] = 1'b0;
      cyc();
      #1;
      chk("lk_hand", hmaster, 2);
      chk("lk_ml0", hmastlock, 0);
`endif

      // random traffic against the model
      clear_all(); do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NM; i++) begin
            if ($urandom_range(0, 7) == 0)  hbusreq[i] = ~hbusreq[i];
            if ($urandom_range(0, 15) == 0) hlock[i]   = ~hlock[i];
            htrans_m[i] = ($urandom_range(0, 15) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            hwrite_m[i] = 1'($urandom_range(0, 1));
            hsize_m[i]  = 3'($urandom_range(0, 2));
            haddr_m[i]  = $urandom;
            hwdata_m[i] = $urandom;
         end
         hready = ($urandom_range(0, 4) != 0);
         rst    = ($urandom_range(0, 199) == 0);
         cyc();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/amba_arbiter.md
# amba_arbiter

Round-robin AHB bus arbiter and master-side multiplexer for the AMBA subsystem. It lets NMASTER `amba_master`-style requesters share the single address/data bus that feeds `amba_deco`, the slave memories and `amba_mux`. It registers a one-hot grant, tracks the address-phase and data-phase owners, and routes the owner's address-phase and write-data signals onto the shared bus. It also enforces a bounded bus tenure and parks the bus on master 0 when no master is requesting.

## Interface
- NMASTER, 4, number of requesting masters (2..8).
- MAX_TENURE, 16, maximum active-transfer beats per grant while another master waits (power of two, ≥2).
- MWIDTH, $clog2(NMASTER), master index width (derived; do not override).
- AWIDTH/DWIDTH come from `amba_pkg`.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- hbusreq  in  NMASTER  bus request, one bit per master.
- hlock  in  NMASTER  locked-transfer request; only meaningful with AMBA_ARB_LOCK_EN.
- haddr_m  in  NMASTER×AWIDTH  per-master address.
- htrans_m  in  NMASTER×2  per-master transfer type.
- hwrite_m  in  NMASTER  per-master write flag.
- hsize_m  in  NMASTER×3  per-master transfer size.
- hwdata_m  in  NMASTER×DWIDTH  per-master write data.
- hready  in  1  shared HREADY from `amba_mux`.
- hgrant  out  NMASTER  registered one-hot grant.
- hmaster  out  MWIDTH  address-phase owner index.
- hmaster_d  out  MWIDTH  data-phase owner index.
- hmastlock  out  1  current transfer is locked.
- haddr  out  AWIDTH  shared bus address.
- htrans  out  2  shared bus transfer type.
- hwrite  out  1  shared bus write flag.
- hsize  out  3  shared bus transfer size.
- hwdata  out  DWIDTH  shared bus write data.

## Operation
- States:
  - PARK: no request pending; grant master 0; htrans is forced to IDLE (2'b00).
  - OWN: a requesting master holds the bus.
- Arbitration is evaluated only on cycles with hready=1.
- Rearbitration point, evaluated in OWN:
  - the owner's hbusreq=0, or
  - the owner's htrans_m=IDLE, or
  - the tenure counter is at MAX_TENURE-1 with an active beat while another master's hbusreq=1.
- Round-robin winner search:
  - Scan starts at (hmaster+1) mod NMASTER and wraps; the first master with hbusreq=1 wins.
  - The current owner is eligible last, so it keeps the bus only if no one else requests.
- Outcomes at a rearbitration point:
  - No requester: go to PARK.
  - In PARK, any request: go to OWN with the round-robin winner. The search starts from the last real owner, which is master 0 after reset.
- Tenure counter:
  - Clears on every grant change.
  - Increments on hready=1 cycles where the owner's htrans is NONSEQ or SEQ.
  - Saturates at MAX_TENURE-1.
- Address-phase mux: haddr/htrans/hwrite/hsize are selected by hmaster, except htrans is IDLE in PARK.
- Write-data mux: hwdata is selected by hmaster_d.

## Timing
- Decision at cycle N (hready=1): hgrant and hmaster update at edge N+1, and the new owner's address phase appears on the bus from cycle N+1.
- hmaster_d <= hmaster on every edge with hready=1; it holds while hready=0.
- hready=0 freezes hgrant, hmaster, hmaster_d, tenure and state.
- Reset values: hgrant=1 (master 0), hmaster=0, hmaster_d=0, hmastlock=0, state PARK, tenure 0, last owner 0. The muxed outputs are therefore master 0's signals with htrans=IDLE.
- Reset asserted mid-transfer: the next edge forces the reset values regardless of hready. No transfer is completed.
- A grant change and a data phase in progress coexist: the old owner's hwdata stays on the bus through its data phase via hmaster_d.
- All outputs are glitch-free combinational muxes of registered selects. No input-to-hgrant combinational path.

## Configuration
- AMBA_ARB_LOCK_EN defined:
  - While the owner's hlock=1, no rearbitration occurs and tenure expiry is ignored.
  - hmastlock = hlock[hmaster] registered alongside hmaster.
  - The grant is released at the first hready=1 cycle after hlock drops and a rearbitration condition holds.
- Not defined: hlock is ignored and hmastlock is tied 0.

## Test plan
- Reset, no requests → hgrant=4'b0001, hmaster=0, htrans=IDLE held for 20 cycles.
- Masters 1 and 2 request continuously with NONSEQ/SEQ, hready=1 → grant alternates 1,2,1,… every 16 active beats; hmaster_d lags hmaster by exactly one hready cycle.
- Master 3 alone issues a write (haddr=0x0000_1004, hwdata=0xDEADBEEF), then hready=0 for 3 cycles → grant, hmaster_d and hwdata frozen, and hwdata=0xDEADBEEF throughout the data phase.
- Master 2 drops hbusreq while master 0 requests → hgrant=4'b0001 at the following edge with hready=1; with no requests the bus returns to PARK and htrans=IDLE.
- rst pulsed while master 1 owns mid-burst → reset values at the next edge, and re-grant to master 1 starts with tenure 0.
- With AMBA_ARB_LOCK_EN: master 1 holds hlock=1 for 40 beats while master 2 requests → no handover and hmastlock=1. Grant passes to master 2 on the first hready=1 after hlock drops.
